// File: rtl/nn_axil_pkg.sv
// Shared constants for the NN accelerator AXI4-Lite config slave.
// Register offsets, capture FSM states and the AXI OKAY response.
package nn_axil_pkg;

  localparam logic [4:0] REG_WEIGHT = 5'd0;
  localparam logic [4:0] REG_BIAS   = 5'd4;
  localparam logic [4:0] REG_RESULT = 5'd8;
  localparam logic [4:0] REG_LAYER  = 5'd12;
  localparam logic [4:0] REG_NEURON = 5'd16;
  localparam logic [4:0] REG_NOUT   = 5'd20;
  localparam logic [4:0] REG_STATUS = 5'd24;
  localparam logic [4:0] REG_CTRL   = 5'd28;

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_HOLD    = 1'b1
  } cap_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/nn_out_capture_buf.sv
// Final-layer neuron output capture buffer with CAPTURE/HOLD FSM.
// Overflow flag is stored only when NN_AXIL_STATUS_REG_EN is defined.
module nn_out_capture_buf
  import nn_axil_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_OUT    = 10,
  parameter int PTR_W      = $clog2(NUM_OUT + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_frame_done,
  input  logic                  i_pop,
  input  logic                  i_clear,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_hold,
  output logic                  o_overflow,
  output logic [PTR_W-1:0]      o_wr_ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_OUT);

  cap_state_e            r_state;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_buf [NUM_OUT];

  logic                  w_we;
  logic [PTR_W-1:0]      w_widx;
  logic [PTR_W-1:0]      w_wp_a;
  logic [PTR_W-1:0]      w_rp_a;
  logic                  w_can_pop;

  // Pointers after the write; the pop then works on these.
  always_comb begin
    w_we   = 1'b0;
    w_widx = r_wr_ptr;
    w_wp_a = r_wr_ptr;
    w_rp_a = r_rd_ptr;
    if (i_wr_valid) begin
      if (r_state == ST_HOLD) begin
        w_we   = 1'b1;
        w_widx = '0;
        w_wp_a = PTR_W'(1);
        w_rp_a = '0;
      end else if (r_wr_ptr < LAST) begin
        w_we   = 1'b1;
        w_wp_a = r_wr_ptr + 1'b1;
      end
    end
  end

  assign w_can_pop = i_pop && (w_rp_a != w_wp_a);

  always_comb begin
    o_rd_data = '0;
    if (w_can_pop) begin
      if (w_we && (w_widx == w_rp_a))
        o_rd_data = i_wr_data;
      else
        o_rd_data = r_buf[w_rp_a];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_CAPTURE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= w_wp_a;
      r_rd_ptr <= w_can_pop ? w_rp_a + 1'b1 : w_rp_a;
      if (i_frame_done)
        r_state <= ST_HOLD;
      else if (i_wr_valid)
        r_state <= ST_CAPTURE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we)
      r_buf[w_widx] <= i_wr_data;
  end

`ifdef NN_AXIL_STATUS_REG_EN
  logic r_overflow;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear)
      r_overflow <= 1'b0;
    else if (i_wr_valid && (r_state == ST_CAPTURE) && (r_wr_ptr == LAST))
      r_overflow <= 1'b1;
  end

  assign o_overflow = r_overflow;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_hold   = (r_state == ST_HOLD);
  assign o_wr_ptr = r_wr_ptr;

endmodule

// File: rtl/nn_axil_cfg_slave.sv
// AXI4-Lite config/readback slave for the NN accelerator core.
// Define NN_AXIL_STATUS_REG_EN for the status (24) and control (28) regs.
module nn_axil_cfg_slave
  import nn_axil_pkg::*;
#(
  parameter int DATA_WIDTH         = 16,
  parameter int NUM_OUT            = 10,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic                          weight_valid,
  output logic [DATA_WIDTH-1:0]         weight_data,
  output logic                          bias_valid,
  output logic [DATA_WIDTH-1:0]         bias_data,
  output logic [31:0]                   layer_no,
  output logic [31:0]                   neuron_no,
  input  logic                          nn_out_valid,
  input  logic [31:0]                   nn_out_data,
  input  logic                          neuron_out_valid,
  input  logic [DATA_WIDTH-1:0]         neuron_out_data,
  output logic                          intr
);

  localparam int PTR_W = $clog2(NUM_OUT + 1);

  logic                          r_rdy_en;
  logic                          r_aw_lat;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic                          r_w_lat;
  logic [31:0]                   r_wdata;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [31:0]                   r_rdata;
  logic                          r_weight_valid;
  logic [DATA_WIDTH-1:0]         r_weight_data;
  logic                          r_bias_valid;
  logic [DATA_WIDTH-1:0]         r_bias_data;
  logic [31:0]                   r_layer;
  logic [31:0]                   r_neuron;
  logic [31:0]                   r_result;
  logic                          r_intr;

  logic                          w_awready;
  logic                          w_wready;
  logic                          w_aw_hs;
  logic                          w_w_hs;
  logic                          w_fire;
  logic                          w_ar_hs;
  logic [4:0]                    w_woff;
  logic [4:0]                    w_roff;
  logic                          w_wr_weight;
  logic                          w_wr_bias;
  logic                          w_wr_layer;
  logic                          w_wr_neuron;
  logic                          w_ctrl_clr;
  logic                          w_rd_result;
  logic                          w_pop;
  logic [DATA_WIDTH-1:0]         w_nout;
  logic                          w_hold;
  logic                          w_overflow;
  logic [PTR_W-1:0]              w_wr_ptr;
  logic [31:0]                   w_status;
  logic [31:0]                   w_rmux;
  logic                          w_unused;

  assign w_awready = r_rdy_en && !r_aw_lat && !r_bvalid;
  assign w_wready  = r_rdy_en && !r_w_lat && !r_bvalid;
  assign w_aw_hs   = s_axi_awvalid && w_awready;
  assign w_w_hs    = s_axi_wvalid && w_wready;
  assign w_fire    = r_aw_lat && r_w_lat;
  assign w_ar_hs   = s_axi_arvalid && r_arready;
  assign w_woff    = 5'(r_awaddr);
  assign w_roff    = 5'(s_axi_araddr);

  assign w_wr_weight = w_fire && (w_woff == REG_WEIGHT);
  assign w_wr_bias   = w_fire && (w_woff == REG_BIAS);
  assign w_wr_layer  = w_fire && (w_woff == REG_LAYER);
  assign w_wr_neuron = w_fire && (w_woff == REG_NEURON);
  assign w_rd_result = w_ar_hs && (w_roff == REG_RESULT);
  assign w_pop       = w_ar_hs && (w_roff == REG_NOUT);

`ifdef NN_AXIL_STATUS_REG_EN
  assign w_ctrl_clr = w_fire && (w_woff == REG_CTRL) && r_wdata[0];
`else
  assign w_ctrl_clr = 1'b0;
`endif

  nn_out_capture_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_OUT    (NUM_OUT),
    .PTR_W      (PTR_W)
  ) u_cap (
    .i_clk        (s_axi_aclk),
    .i_rst        (s_axi_areset),
    .i_wr_valid   (neuron_out_valid),
    .i_wr_data    (neuron_out_data),
    .i_frame_done (nn_out_valid),
    .i_pop        (w_pop),
    .i_clear      (w_ctrl_clr),
    .o_rd_data    (w_nout),
    .o_hold       (w_hold),
    .o_overflow   (w_overflow),
    .o_wr_ptr     (w_wr_ptr)
  );

  assign w_status = {20'd0, 4'(w_wr_ptr), 5'd0, w_overflow, w_hold, r_intr};
  assign w_unused = ^{s_axi_wstrb, w_status};

  always_comb begin
    w_rmux = '0;
    unique case (1'b1)
      (w_roff == REG_RESULT): w_rmux = r_result;
      (w_roff == REG_LAYER):  w_rmux = r_layer;
      (w_roff == REG_NEURON): w_rmux = r_neuron;
      (w_roff == REG_NOUT):   w_rmux = 32'(w_nout);
`ifdef NN_AXIL_STATUS_REG_EN
      (w_roff == REG_STATUS): w_rmux = w_status;
`endif
      default:                w_rmux = '0;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_rdy_en       <= 1'b0;
      r_aw_lat       <= 1'b0;
      r_awaddr       <= '0;
      r_w_lat        <= 1'b0;
      r_wdata        <= '0;
      r_bvalid       <= 1'b0;
      r_arready      <= 1'b0;
      r_rvalid       <= 1'b0;
      r_rdata        <= '0;
      r_weight_valid <= 1'b0;
      r_weight_data  <= '0;
      r_bias_valid   <= 1'b0;
      r_bias_data    <= '0;
      r_layer        <= '0;
      r_neuron       <= '0;
      r_result       <= '0;
      r_intr         <= 1'b0;
    end else begin
      r_rdy_en       <= 1'b1;
      r_weight_valid <= w_wr_weight;
      r_bias_valid   <= w_wr_bias;
      if (w_wr_weight)
        r_weight_data <= r_wdata[DATA_WIDTH-1:0];
      if (w_wr_bias)
        r_bias_data <= r_wdata[DATA_WIDTH-1:0];
      if (w_wr_layer)
        r_layer <= r_wdata;
      if (w_wr_neuron)
        r_neuron <= r_wdata;

      if (w_aw_hs) begin
        r_aw_lat <= 1'b1;
        r_awaddr <= s_axi_awaddr;
      end else if (w_fire) begin
        r_aw_lat <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_lat <= 1'b1;
        r_wdata <= s_axi_wdata;
      end else if (w_fire) begin
        r_w_lat <= 1'b0;
      end

      if (w_fire)
        r_bvalid <= 1'b1;
      else if (s_axi_bready)
        r_bvalid <= 1'b0;

      r_arready <= s_axi_arvalid && !r_arready && !r_rvalid;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rmux;
      end else if (s_axi_rready) begin
        r_rvalid <= 1'b0;
      end

      // A new result beats a same-cycle clear from read or control.
      if (nn_out_valid) begin
        r_result <= nn_out_data;
        r_intr   <= 1'b1;
      end else if (w_rd_result || w_ctrl_clr) begin
        r_intr <= 1'b0;
      end
    end
  end

  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_arready = r_arready;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = RESP_OKAY;
  assign s_axi_rvalid  = r_rvalid;
  assign weight_valid  = r_weight_valid;
  assign weight_data   = r_weight_data;
  assign bias_valid    = r_bias_valid;
  assign bias_data     = r_bias_data;
  assign layer_no      = r_layer;
  assign neuron_no     = r_neuron;
  assign intr          = r_intr;

endmodule

// File: tb/tb_nn_axil_cfg_slave.sv
// Directed, table-driven bench for nn_axil_cfg_slave.
// Status/control checks run only with NN_AXIL_STATUS_REG_EN defined.
module tb_nn_axil_cfg_slave;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          areset;
  logic [4:0]    awaddr;
  logic          awvalid;
  logic          awready;
  logic [31:0]   wdata;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [4:0]    araddr;
  logic          arvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic          weight_valid;
  logic [DW-1:0] weight_data;
  logic          bias_valid;
  logic [DW-1:0] bias_data;
  logic [31:0]   layer_no;
  logic [31:0]   neuron_no;
  logic          nn_out_valid;
  logic [31:0]   nn_out_data;
  logic          neuron_out_valid;
  logic [DW-1:0] neuron_out_data;
  logic          intr;

  int errors = 0;
  int checks = 0;
  int wcnt = 0;
  int bcnt = 0;
  int bresp_cnt = 0;
  logic [DW-1:0] wlast = '0;
  logic [DW-1:0] blast = '0;

  always #5 clk = ~clk;

  nn_axil_cfg_slave dut (
    .s_axi_aclk       (clk),
    .s_axi_areset     (areset),
    .s_axi_awaddr     (awaddr),
    .s_axi_awvalid    (awvalid),
    .s_axi_awready    (awready),
    .s_axi_wdata      (wdata),
    .s_axi_wstrb      (4'hF),
    .s_axi_wvalid     (wvalid),
    .s_axi_wready     (wready),
    .s_axi_bresp      (bresp),
    .s_axi_bvalid     (bvalid),
    .s_axi_bready     (bready),
    .s_axi_araddr     (araddr),
    .s_axi_arvalid    (arvalid),
    .s_axi_arready    (arready),
    .s_axi_rdata      (rdata),
    .s_axi_rresp      (rresp),
    .s_axi_rvalid     (rvalid),
    .s_axi_rready     (rready),
    .weight_valid     (weight_valid),
    .weight_data      (weight_data),
    .bias_valid       (bias_valid),
    .bias_data        (bias_data),
    .layer_no         (layer_no),
    .neuron_no        (neuron_no),
    .nn_out_valid     (nn_out_valid),
    .nn_out_data      (nn_out_data),
    .neuron_out_valid (neuron_out_valid),
    .neuron_out_data  (neuron_out_data),
    .intr             (intr)
  );

  always @(posedge clk) begin
    if (weight_valid) begin
      wcnt++;
      wlast = weight_data;
    end
    if (bias_valid) begin
      bcnt++;
      blast = bias_data;
    end
    if (bvalid && bready)
      bresp_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr_start(input logic [4:0] a, input logic [31:0] d);
    bit ad, wd, sa, sw;
    ad = 0;
    wd = 0;
    awaddr = a;
    awvalid = 1;
    wdata = d;
    wvalid = 1;
    for (int n = 0; n < 40 && !(ad && wd); n++) begin
      @(negedge clk);
      sa = awvalid && awready;
      sw = wvalid && wready;
      @(posedge clk); #1;
      if (sa) begin awvalid = 0; ad = 1; end
      if (sw) begin wvalid = 0; wd = 1; end
    end
    awvalid = 0;
    wvalid = 0;
    chk("wr_handshake", {30'd0, ad, wd}, 32'd3);
  endtask

  task automatic b_wait();
    bit ok;
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; break; end
    end
    chk("b_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic b_finish();
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_start(a, d);
    b_wait();
    b_finish();
  endtask

  task automatic rd_start(input logic [4:0] a);
    bit hs;
    hs = 0;
    araddr = a;
    arvalid = 1;
    for (int n = 0; n < 40 && !hs; n++) begin
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
    end
    arvalid = 0;
    chk("ar_handshake", {31'd0, hs}, 32'd1);
  endtask

  task automatic r_wait(output logic [31:0] d);
    bit ok;
    ok = 0;
    d = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; d = rdata; break; end
    end
    chk("r_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    rd_start(a);
    r_wait(d);
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    neuron_out_valid = 1;
    neuron_out_data = d;
    @(posedge clk); #1;
    neuron_out_valid = 0;
  endtask

  task automatic nnres(input logic [31:0] d);
    nn_out_valid = 1;
    nn_out_data = d;
    @(posedge clk); #1;
    nn_out_valid = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int w0, b0, r0;
    bit hs;

    areset = 1;
    awaddr = 0; awvalid = 0; wdata = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    nn_out_valid = 0; nn_out_data = 0;
    neuron_out_valid = 0; neuron_out_data = 0;

    tbl[0]  = '{1, 5'd12, 32'd2};
    tbl[1]  = '{1, 5'd16, 32'd5};
    tbl[2]  = '{0, 5'd12, 32'd2};
    tbl[3]  = '{0, 5'd16, 32'd5};
    tbl[4]  = '{1, 5'd12, 32'hDEADBEEF};
    tbl[5]  = '{0, 5'd12, 32'hDEADBEEF};
    tbl[6]  = '{0, 5'd0,  32'd0};
    tbl[7]  = '{0, 5'd4,  32'd0};
    tbl[8]  = '{1, 5'd2,  32'h55};
    tbl[9]  = '{0, 5'd12, 32'hDEADBEEF};
    tbl[10] = '{0, 5'd16, 32'd5};
    tbl[11] = '{0, 5'd30, 32'd0};
    tbl[12] = '{0, 5'd8,  32'd0};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_awready", {31'd0, awready}, 0);
    chk("rst_wready", {31'd0, wready}, 0);
    chk("rst_arready", {31'd0, arready}, 0);
    chk("rst_bvalid", {31'd0, bvalid}, 0);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    chk("rst_intr", {31'd0, intr}, 0);
    chk("rst_weight_valid", {31'd0, weight_valid}, 0);
    chk("rst_layer", layer_no, 0);
    chk("rst_neuron", neuron_no, 0);
    chk("rst_rdata", rdata, 0);
    areset = 0;
    @(posedge clk); #1;

    // weight strobe coincides with bvalid, B held until bready
    wr_start(5'd0, 32'h0000_1A3C);
    b_wait();
    chk("wv_with_b", {31'd0, weight_valid}, 1);
    chk("wdata_at_b", {16'd0, weight_data}, 32'h1A3C);
    repeat (3) begin
      @(negedge clk);
      chk("b_held", {31'd0, bvalid}, 1);
    end
    b_finish();
    @(negedge clk);
    chk("b_dropped", {31'd0, bvalid}, 0);
    chk("weight_count", wcnt, 1);
    chk("weight_last", {16'd0, wlast}, 32'h1A3C);
    @(posedge clk); #1;

    w0 = wcnt;
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        wr(tbl[i].addr, tbl[i].data);
        if (tbl[i].addr == 5'd12)
          chk($sformatf("vec%0d_layer", i), layer_no, tbl[i].data);
        if (tbl[i].addr == 5'd16)
          chk($sformatf("vec%0d_neuron", i), neuron_no, tbl[i].data);
      end else begin
        rd(tbl[i].addr, d);
        chk($sformatf("vec%0d_rd%0d", i, tbl[i].addr), d, tbl[i].data);
      end
    end
    chk("no_stray_weight", wcnt, w0);

    // AW three cycles ahead of W
    b0 = bcnt;
    r0 = bresp_cnt;
    awaddr = 5'd4;
    awvalid = 1;
    @(negedge clk);
    chk("aw_early_ready", {31'd0, awready}, 1);
    @(posedge clk); #1;
    awvalid = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("aw_latched_busy", {31'd0, awready}, 0);
    chk("w_still_ready", {31'd0, wready}, 1);
    chk("no_bias_yet", bcnt, b0);
    wdata = 32'h0000_0042;
    wvalid = 1;
    @(posedge clk); #1;
    wvalid = 0;
    b_wait();
    chk("bias_with_b", {31'd0, bias_valid}, 1);
    b_finish();
    repeat (3) @(posedge clk);
    #1;
    chk("bias_count", bcnt - b0, 1);
    chk("bias_data", {16'd0, blast}, 32'h42);
    chk("b_count", bresp_cnt - r0, 1);

    // full frame capture and readback
    for (int i = 0; i < 10; i++) push(DW'(16'h0100 + i));
    nnres(32'd7);
    @(negedge clk);
    chk("intr_set", {31'd0, intr}, 1);
    rd(5'd8, d);
    chk("result7", d, 32'd7);
    @(negedge clk);
    chk("intr_cleared", {31'd0, intr}, 0);
    for (int i = 0; i < 10; i++) begin
      rd(5'd20, d);
      chk($sformatf("pop%0d", i), d, 32'h0100 + i);
    end
    rd(5'd20, d);
    chk("pop_empty", d, 0);

    // 12 outputs: first leaves HOLD, last two dropped
    for (int i = 0; i < 12; i++) push(DW'(16'h0200 + i));
`ifdef NN_AXIL_STATUS_REG_EN
    rd(5'd24, d);
    chk("st_overflow", {31'd0, d[2]}, 1);
    chk("st_capture", {31'd0, d[1]}, 0);
    chk("st_wr_ptr", {28'd0, d[11:8]}, 10);
`endif
    nnres(32'd1);
    for (int i = 0; i < 10; i++) begin
      rd(5'd20, d);
      chk($sformatf("ovf_pop%0d", i), d, 32'h0200 + i);
    end
    rd(5'd20, d);
    chk("ovf_pop_empty", d, 0);
    push(DW'(16'h0300));
    rd(5'd20, d);
    chk("new_frame_buf0", d, 32'h0300);
    rd(5'd20, d);
    chk("new_frame_empty", d, 0);
`ifdef NN_AXIL_STATUS_REG_EN
    wr(5'd28, 32'd1);
    rd(5'd24, d);
    chk("ctrl_clr_status", d, 0);
`endif

    // reset with B and R responses pending
    wr(5'd12, 32'h77);
    wr(5'd16, 32'd9);
    nnres(32'd5);
    wr_start(5'd12, 32'h33);
    b_wait();
    @(posedge clk); #1;
    rd_start(5'd12);
    r_wait(d);
    chk("pre_bvalid", {31'd0, bvalid}, 1);
    chk("pre_rvalid", {31'd0, rvalid}, 1);
    areset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_bvalid", {31'd0, bvalid}, 0);
    chk("mid_rst_rvalid", {31'd0, rvalid}, 0);
    chk("mid_rst_intr", {31'd0, intr}, 0);
    chk("mid_rst_layer", layer_no, 0);
    chk("mid_rst_neuron", neuron_no, 0);
    areset = 0;
    @(posedge clk); #1;
    rd(5'd20, d);
    chk("post_rst_pop", d, 0);

    // result read racing a new result
    nnres(32'd9);
    araddr = 5'd8;
    arvalid = 1;
    hs = 0;
    for (int n = 0; n < 40 && !hs; n++) begin
      @(negedge clk);
      hs = arready;
      if (hs) begin
        nn_out_valid = 1;
        nn_out_data = 32'd3;
      end
      @(posedge clk); #1;
      nn_out_valid = 0;
    end
    arvalid = 0;
    chk("race_handshake", {31'd0, hs}, 1);
    r_wait(d);
    chk("race_old_result", d, 32'd9);
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    chk("race_intr_kept", {31'd0, intr}, 1);
    rd(5'd8, d);
    chk("race_new_result", d, 32'd3);
    @(negedge clk);
    chk("race_intr_clear", {31'd0, intr}, 0);
    chk("bresp_okay", {30'd0, bresp}, 0);
    chk("rresp_okay", {30'd0, rresp}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nn_axil_cfg_slave.md
Name: nn_axil_cfg_slave

Overview:
AXI4-Lite responder (slave) register block for the NN accelerator top level. It accepts configuration writes from the host, drives the weight, bias, layer-select and neuron-select strobes into the layer array, and captures the classification result and final-layer neuron outputs for host readback. It also raises the completion interrupt. It sits between the host AXI-Lite port and the generated network core.

Parameters:
DATA_WIDTH, 16, weight/bias/neuron-output width (low bits of 32-bit wdata/rdata)
NUM_OUT, 10, final-layer neuron count (capture buffer depth)
C_S_AXI_ADDR_WIDTH, 5, decoded address bits (word offsets 0..28)

Ports:
s_axi_aclk  in  1  clock
s_axi_areset  in  1  reset, synchronous active-high
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
s_axi_wdata  in  32  write data; s_axi_wstrb in 4 (ignored, full-word writes)
s_axi_wvalid / s_axi_wready  in/out  1  W handshake
s_axi_bresp  out  2  always 2'b00
s_axi_bvalid / s_axi_bready  out/in  1  B handshake
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
s_axi_rdata  out  32  read data; s_axi_rresp out 2, always 2'b00
s_axi_rvalid / s_axi_rready  out/in  1  R handshake
weight_valid / weight_data  out  1 / DATA_WIDTH  one-cycle weight strobe
bias_valid / bias_data  out  1 / DATA_WIDTH  one-cycle bias strobe
layer_no / neuron_no  out  32 / 32  config target select
nn_out_valid / nn_out_data  in  1 / 32  result pulse, detected class
neuron_out_valid / neuron_out_data  in  1 / DATA_WIDTH  final-layer output stream
intr  out  1  result-ready interrupt, level

Behaviour:
- Reset: all outputs 0, including every ready/valid, intr, layer_no, neuron_no and rdata. Capture buffer is emptied and the FSM goes to CAPTURE. Reset mid-transaction drops any pending B or R response.
- Register map (word offsets):
  - 0: write emits weight_valid for one cycle with wdata[DATA_WIDTH-1:0].
  - 4: write emits bias_valid the same way.
  - 8: read returns the result register; the read also clears intr.
  - 12: layer_no, read/write.
  - 16: neuron_no, read/write.
  - 20: read pops the next buffered neuron output, zero-extended.
  - Unmapped write: accepted with OKAY, no effect. Unmapped read: returns 0.
- Write channel:
  - AW and W are latched independently. awready/wready are each high when that channel is not latched and bvalid=0.
  - Once both are latched, the register update or strobe fires on the following cycle, and bvalid rises in that same cycle.
  - bvalid holds until bready. No new AW/W is accepted while bvalid=1.
  - Same-cycle AW+W is supported.
- Read channel:
  - arready is high for one cycle when arvalid=1 and rvalid=0.
  - rdata/rvalid are registered on the next cycle and held until rready.
  - Read and write channels operate concurrently.
- Result: nn_out_valid latches nn_out_data into the result register and sets intr. If nn_out_valid and a read of offset 8 complete in the same cycle, the set wins: intr stays 1 and the new data is stored.
- Capture buffer FSM:
  - CAPTURE: each neuron_out_valid writes the buffer at wr_ptr and increments wr_ptr. Writes beyond NUM_OUT entries are dropped. nn_out_valid moves the FSM to HOLD.
  - HOLD: a read of offset 20 returns buf[rd_ptr] and increments rd_ptr. A read when rd_ptr==wr_ptr returns 0 and does not advance.
  - HOLD exit: the first neuron_out_valid seen in HOLD clears both pointers, stores that entry at index 0 (wr_ptr=1), and returns the FSM to CAPTURE.
  - neuron_out_valid and a read of offset 20 in the same cycle: the write is handled first, the pop then proceeds on the updated pointers.

Optional Feature:
- NN_AXIL_STATUS_REG_EN defined:
  - Offset 24 is read-only status: bit0 intr, bit1 FSM state (1=HOLD), bit2 overflow (neuron write dropped), bits[11:8] wr_ptr.
  - A write to offset 28 with wdata[0]=1 clears the pointers, the overflow flag and intr.
- Undefined: offsets 24/28 behave as unmapped, and no overflow flag is stored.

Decomposition:
- Package nn_axil_pkg: register offset localparams (REG_WEIGHT=0 … REG_CTRL=28), the FSM state enum, and the OKAY response constant.
- One sub-module, nn_out_capture_buf: NUM_OUT×DATA_WIDTH storage with wr/rd pointers, the CAPTURE/HOLD FSM and the overflow flag.

Test Plan:
- Write 12←2, 16←5, 0←0x1A3C → layer_no=2, neuron_no=5, one-cycle weight_valid with weight_data=0x1A3C, bvalid held until bready. Read back 12 and 16 → 2 and 5.
- AW presented 3 cycles before W, then write 4←0x0042 → exactly one bias_valid pulse, data 0x0042, one B response.
- Stream 10 neuron outputs 0x0100..0x0109, then nn_out_valid with data 7 → intr=1. Read 8 → 7 and intr drops. Ten reads of 20 → 0x0100..0x0109. 11th read → 0.
- Send 12 neuron outputs → the first 10 are stored, with overflow=1 when NN_AXIL_STATUS_REG_EN is defined. A new frame's first output while in HOLD → pointers cleared and buf[0] = new value.
- Assert reset with bvalid=1 and rvalid pending → next cycle all valids, intr, layer_no and neuron_no are 0. Read 20 → 0.
- Read 8 completing in the same cycle as nn_out_valid(3) → intr stays 1 and the next read of 8 returns 3.
